shift_seq: RTL and testbench

SHIFT_SEQ -- requirements
Module: shift_seq

---
 rtl/shift_seq.sv | 104 ++++++++++
 tb/tb_shift_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq.sv
// shift_seq: sequential right shifter that moves the operand one bit per
// clock. A start loads the operand and a shift count. The block then shifts
// once per cycle until the count runs out, and pulses done for one cycle.
// Optional feature: define SHIFT_SEQ_ARITH_EN to add an 'arith' input. When
// arith is set at start, the vacated MSBs are filled with the operand's sign
// bit instead of zero. WIDTH is expected to be at least 2.
module shift_seq #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [AMT_W-1:0] amt,
`ifdef SHIFT_SEQ_ARITH_EN
    input  logic             arith,
`endif
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [AMT_W-1:0] count;
    logic             fill;
    logic             accept;
    logic             last_shift;

    // A start only counts when no shift is running; in SHIFT it is dropped
    assign accept     = start && ((state == IDLE) || (state == DONE));
    assign last_shift = (count == AMT_W'(1));

    // Next-state selection; DONE falls back to IDLE unless restarted
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_next = (amt != '0) ? SHIFT : DONE;
                end else begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                if (last_shift) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, cleared asynchronously so a reset aborts any shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

`ifdef SHIFT_SEQ_ARITH_EN
    // Fill bit is latched with the operand, so later input changes do not matter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill <= 1'b0;
        end else if (accept) begin
            fill <= arith & a[WIDTH-1];
        end
    end
`else
    assign fill = 1'b0;
`endif

    // Datapath: load on accept, one-bit shift per SHIFT cycle, else hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out   <= '0;
            carry <= 1'b0;
            count <= '0;
        end else if (accept) begin
            out   <= a;
            carry <= 1'b0;
            count <= amt;
        end else if (state == SHIFT) begin
            carry <= out[0];
            out   <= {fill, out[WIDTH-1:1]};
            count <= count - AMT_W'(1);
        end
    end

    assign zero = (out == '0);
    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: scoreboard bench for shift_seq. Stimulus pushes expected
// results computed from the shift rules; a monitor compares them against
// done pulses, busy and the held outputs every cycle.
// Honours SHIFT_SEQ_ARITH_EN the same way the design does.
module tb_shift_seq;

    localparam int W     = 4;
    localparam int AMT_W = 3;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [W-1:0]     a;
    logic [AMT_W-1:0] amt;
    logic             arith;
    logic [W-1:0]     out;
    logic             carry;
    logic             zero;
    logic             busy;
    logic             done;

    typedef struct {
        int           n;
        int           amt;
        logic [W-1:0] out;
        logic         carry;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    int   last_end = -1;
    int   tests    = 0;
    int   fails    = 0;
    logic [W-1:0] hold_out   = '0;
    logic         hold_carry = 1'b0;

    shift_seq #(.WIDTH(W), .AMT_W(AMT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .amt   (amt),
`ifdef SHIFT_SEQ_ARITH_EN
        .arith (arith),
`endif
        .out   (out),
        .carry (carry),
        .zero  (zero),
        .busy  (busy),
        .done  (done)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to time done pulses
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Shift rules: bit i takes source bit i+amt, or the fill once past the MSB
    function automatic void model(input logic [W-1:0] av, input int amtv, input logic ar,
                                  output logic [W-1:0] o, output logic c);
        logic f;
        f = ar & av[W-1];
        for (int i = 0; i < W; i++) begin
            o[i] = (i + amtv < W) ? av[i + amtv] : f;
        end
        if (amtv == 0) c = 1'b0;
        else if (amtv - 1 < W) c = av[amtv - 1];
        else c = f;
    endfunction

    task automatic apply_stimulus(input logic [W-1:0] av, input logic [AMT_W-1:0] amtv, input logic ar);
        exp_t e;
        logic eff_ar;
        @(negedge clk);
`ifdef SHIFT_SEQ_ARITH_EN
        eff_ar = ar;
`else
        eff_ar = 1'b0;
`endif
        start = 1'b1;
        a     = av;
        amt   = amtv;
        arith = eff_ar;
        e.n   = cyc + 1;
        e.amt = int'(amtv);
        if (e.n > last_end) begin
            model(av, e.amt, eff_ar, e.out, e.carry);
            q.push_back(e);
            last_end = e.n + e.amt;
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic drain();
        int budget;
        budget = 100;
        while (q.size() > 0 && budget > 0) begin
            idle_cycles(1);
            budget--;
        end
        check_output("drain_timeout", q.size(), 0);
        idle_cycles(1);
    endtask

    task automatic reset_mid_shift();
        apply_stimulus(4'b1111, 3'd7, 1'b0);
        idle_cycles(2);
        #2 rst_n = 1'b0;
        #1;
        check_output("rst_out",   out,   0);
        check_output("rst_carry", carry, 0);
        check_output("rst_busy",  busy,  0);
        check_output("rst_done",  done,  0);
        check_output("rst_zero",  zero,  1);
        q.delete();
        last_end   = -1;
        hold_out   = '0;
        hold_carry = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: after each edge compare done/busy and results against the queue
    always begin
        @(posedge clk);
        #1;
        if (rst_n) begin
            logic exp_done;
            logic exp_busy;
            exp_done = (q.size() > 0) && (q[0].n + q[0].amt == cyc);
            exp_busy = (q.size() > 0) && (q[0].amt != 0) &&
                       (cyc >= q[0].n) && (cyc < q[0].n + q[0].amt);
            check_output("done", done, exp_done);
            if (exp_done) begin
                check_output("out",   out,   q[0].out);
                check_output("carry", carry, q[0].carry);
                check_output("zero",  zero,  (q[0].out == '0));
                check_output("busy_in_done", busy, 0);
                hold_out   = q[0].out;
                hold_carry = q[0].carry;
                void'(q.pop_front());
            end else if (exp_busy) begin
                check_output("busy", busy, 1);
            end else begin
                check_output("busy_idle",  busy,  0);
                check_output("hold_out",   out,   hold_out);
                check_output("hold_carry", carry, hold_carry);
            end
        end
    end

    // Stimulus: reset, directed cases, then randomized traffic
    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        amt   = '0;
        arith = 1'b0;
        #3;
        check_output("init_out",  out,  0);
        check_output("init_zero", zero, 1);
        check_output("init_busy", busy, 0);
        check_output("init_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2);

        apply_stimulus(4'b0001, 3'd1, 1'b0);
        drain();
        apply_stimulus(4'b1000, 3'd3, 1'b0);
        drain();
        apply_stimulus(4'b1011, 3'd0, 1'b0);
        drain();
        apply_stimulus(4'b0010, 3'd2, 1'b0);
        apply_stimulus(4'b1111, 3'd5, 1'b0);
        drain();
        apply_stimulus(4'b1111, 3'd5, 1'b0);
        drain();
        apply_stimulus(4'b0110, 3'd1, 1'b0);
        idle_cycles(1);
        apply_stimulus(4'b0110, 3'd1, 1'b0);
        drain();
        apply_stimulus(4'b1010, 3'd0, 1'b0);
        apply_stimulus(4'b0101, 3'd0, 1'b0);
        drain();
`ifdef SHIFT_SEQ_ARITH_EN
        apply_stimulus(4'b1001, 3'd1, 1'b1);
        drain();
        apply_stimulus(4'b1000, 3'd2, 1'b1);
        drain();
        apply_stimulus(4'b1000, 3'd7, 1'b1);
        drain();
`endif
        reset_mid_shift();
        idle_cycles(1);
        apply_stimulus(4'b1100, 3'd2, 1'b0);
        drain();

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                apply_stimulus(W'($urandom), AMT_W'($urandom), 1'($urandom));
            end else begin
                idle_cycles(1);
            end
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
